// File: rtl/ama_riscv_perf_cnt_if.sv
// Read bus of the performance-counter unit: one request per cycle, data back
// one cycle later with a valid strobe.
interface ama_riscv_perf_cnt_if;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        output rd_valid
    );
endinterface

// File: rtl/ama_riscv_perf_cnt.sv
// Memory-mapped performance counters fed by writeback retirement status.
// 64-bit cycle/instret plus stall/bubble counters, with hi-word read shadows.
module ama_riscv_perf_cnt #(
    parameter int AUX_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inst_wb_nop_or_clear,
    input  logic                     wb_stall,
    input  logic                     mmio_reset_cnt,
    input  logic                     tohost_done,
    ama_riscv_perf_cnt_if.slave      bus
);

    localparam int CNT_W = 64;

    logic [CNT_W-1:0] cycle_q,     cycle_d;
    logic [CNT_W-1:0] instret_q,   instret_d;
    logic [AUX_W-1:0] stall_q,     stall_d;
    logic [AUX_W-1:0] bubble_q,    bubble_d;
    logic [31:0]      cyc_hi_sh_q, cyc_hi_sh_d;
    logic [31:0]      ins_hi_sh_q, ins_hi_sh_d;
    logic             frozen_q,    frozen_d;
    logic             ovf_q,       ovf_d;
    logic [31:0]      rd_data_q,   rd_data_d;
    logic             rd_valid_q,  rd_valid_d;

    logic             count_en_s;
    logic             retire_s;
    logic             stall_ev_s;
    logic             bubble_ev_s;
    logic             wrap_s;
    logic [31:0]      rd_mux_s;

    // Event classification: exactly one of retire/stall/bubble per cycle.
    always_comb begin
        count_en_s  = ~frozen_q;
        retire_s    = ~inst_wb_nop_or_clear & ~wb_stall;
        stall_ev_s  = wb_stall;
        bubble_ev_s = inst_wb_nop_or_clear & ~wb_stall;
        wrap_s      = count_en_s & ((&cycle_q)
                                  | (retire_s    & (&instret_q))
                                  | (stall_ev_s  & (&stall_q))
                                  | (bubble_ev_s & (&bubble_q)));
    end

    // Counter, flag and shadow next-state; a clear strobe overrides counting.
    always_comb begin
        cycle_d     = cycle_q;
        instret_d   = instret_q;
        stall_d     = stall_q;
        bubble_d    = bubble_q;
        cyc_hi_sh_d = cyc_hi_sh_q;
        ins_hi_sh_d = ins_hi_sh_q;
        ovf_d       = ovf_q;
        frozen_d    = frozen_q;

        if (mmio_reset_cnt) begin
            cycle_d     = {CNT_W{1'b0}};
            instret_d   = {CNT_W{1'b0}};
            stall_d     = {AUX_W{1'b0}};
            bubble_d    = {AUX_W{1'b0}};
            cyc_hi_sh_d = 32'd0;
            ins_hi_sh_d = 32'd0;
            ovf_d       = 1'b0;
        end else begin
            if (count_en_s) begin
                cycle_d   = cycle_q + 64'd1;
                instret_d = retire_s    ? instret_q + 64'd1 : instret_q;
                stall_d   = stall_ev_s  ? stall_q + AUX_W'(1) : stall_q;
                bubble_d  = bubble_ev_s ? bubble_q + AUX_W'(1) : bubble_q;
                ovf_d     = ovf_q | wrap_s;
            end else begin
                cycle_d   = cycle_q;
            end
            // Shadows take the same pre-update value the lo read returns.
            if (bus.rd_en && (bus.rd_addr == 3'd0)) begin
                cyc_hi_sh_d = cycle_q[63:32];
            end else if (bus.rd_en && (bus.rd_addr == 3'd2)) begin
                ins_hi_sh_d = instret_q[63:32];
            end else begin
                cyc_hi_sh_d = cyc_hi_sh_q;
            end
        end

        // Freeze is sticky; only a clear with tohost low releases it.
        if (tohost_done) begin
            frozen_d = 1'b1;
        end else if (mmio_reset_cnt) begin
            frozen_d = 1'b0;
        end else begin
            frozen_d = frozen_q;
        end
    end

    // Read mux over the pre-update register values.
    always_comb begin
        rd_mux_s = 32'd0;
        case (bus.rd_addr)
            3'd0:    rd_mux_s = cycle_q[31:0];
            3'd1:    rd_mux_s = cyc_hi_sh_q;
            3'd2:    rd_mux_s = instret_q[31:0];
            3'd3:    rd_mux_s = ins_hi_sh_q;
            3'd4:    rd_mux_s = 32'(stall_q);
            3'd5:    rd_mux_s = 32'(bubble_q);
            3'd6:    rd_mux_s = {30'd0, ovf_q, frozen_q};
            3'd7:    rd_mux_s = 32'd0;
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Read response; data holds while no request is pending.
    always_comb begin
        rd_valid_d = bus.rd_en;
        if (bus.rd_en) begin
            rd_data_d = rd_mux_s;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q     <= {CNT_W{1'b0}};
            instret_q   <= {CNT_W{1'b0}};
            stall_q     <= {AUX_W{1'b0}};
            bubble_q    <= {AUX_W{1'b0}};
            cyc_hi_sh_q <= 32'd0;
            ins_hi_sh_q <= 32'd0;
            frozen_q    <= 1'b0;
            ovf_q       <= 1'b0;
            rd_data_q   <= 32'd0;
            rd_valid_q  <= 1'b0;
        end else begin
            cycle_q     <= cycle_d;
            instret_q   <= instret_d;
            stall_q     <= stall_d;
            bubble_q    <= bubble_d;
            cyc_hi_sh_q <= cyc_hi_sh_d;
            ins_hi_sh_q <= ins_hi_sh_d;
            frozen_q    <= frozen_d;
            ovf_q       <= ovf_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

endmodule
